// File: rtl/inst_loader_ctrl_if.sv
// Handshake and memory-port bundle between the instruction loader and its
// neighbours (UART receiver, debug/control unit, fetch stage, instruction memory).
// The master modport is the environment side; the slave modport is the loader.
interface inst_loader_ctrl_if #(
    parameter int NB_DATA = 32,
    parameter int NBYTE   = 8,
    parameter int NB_ADDR = 7
) ();
    logic                 load_start_i;
    logic [NBYTE-1:0]     byte_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    logic                 fetch_en_i;
    logic                 mem_en_write_o;
    logic [NB_ADDR-1:0]   mem_addr_write_o;
    logic [NB_DATA-1:0]   mem_data_o;
    logic                 mem_en_read_o;
    logic                 busy_o;
    logic                 done_o;
    logic [NB_ADDR:0]     word_count_o;
    logic                 error_o;

    modport master (
        output load_start_i, byte_i, byte_valid_i, fetch_en_i,
        input  byte_ready_o, mem_en_write_o, mem_addr_write_o, mem_data_o,
        input  mem_en_read_o, busy_o, done_o, word_count_o, error_o
    );

    modport slave (
        input  load_start_i, byte_i, byte_valid_i, fetch_en_i,
        output byte_ready_o, mem_en_write_o, mem_addr_write_o, mem_data_o,
        output mem_en_read_o, busy_o, done_o, word_count_o, error_o
    );
endinterface

// File: rtl/inst_loader_ctrl.sv
// Instruction memory loader: assembles a big-endian byte stream into words,
// writes them to the instruction memory and blocks fetch reads while loading.
// A load ends on HALT_WORD (which is itself written) or on the last address.
// Optional build macro INST_LOADER_CHECKSUM_EN adds a CHECK state that compares
// one trailing byte against the XOR of all data bytes and flags error_o.
module inst_loader_ctrl #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NBYTE      = 8,
    parameter int                 N_ELEMENTS = 128,
    parameter int                 NB_ADDR    = 7,
    parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    inst_loader_ctrl_if.slave  bus
);
    localparam int NB_PER_WORD = NB_DATA / NBYTE;
    localparam int NB_BCNT     = (NB_PER_WORD > 1) ? $clog2(NB_PER_WORD) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_PER_WORD - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_ELEMENTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3
`ifdef INST_LOADER_CHECKSUM_EN
        , ST_CHECK = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [NB_DATA-1:0]  asm_q, asm_d;        // word under assembly
    logic [NB_BCNT-1:0]  bcnt_q, bcnt_d;      // bytes accepted in current word
    logic [NB_ADDR-1:0]  addr_q, addr_d;      // address of the word being built
    logic [NB_ADDR:0]    wcnt_q, wcnt_d;      // words written this load
    logic [NB_DATA-1:0]  wdata_q, wdata_d;    // memory data port, held outside WRITE
    logic [NB_ADDR-1:0]  waddr_q, waddr_d;    // memory address port, held outside WRITE
`ifdef INST_LOADER_CHECKSUM_EN
    logic [NBYTE-1:0]    xor_q, xor_d;        // running XOR of data bytes
    logic                err_q, err_d;        // sticky checksum mismatch
`endif

    logic byte_ready_s;
    logic byte_take_s;
    logic busy_s;

    // Output decode from the state register.
    always_comb begin
        byte_ready_s = 1'b0;
        busy_s       = 1'b0;
        case (state_q)
            ST_RECV:  begin byte_ready_s = 1'b1; busy_s = 1'b1; end
            ST_WRITE: begin byte_ready_s = 1'b0; busy_s = 1'b1; end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin byte_ready_s = 1'b1; busy_s = 1'b1; end
`endif
            default:  begin byte_ready_s = 1'b0; busy_s = 1'b0; end
        endcase
    end

    assign byte_take_s = bus.byte_valid_i & byte_ready_s;

    // Next-state and datapath computation.
    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
`ifdef INST_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.load_start_i) begin
                    state_d = ST_RECV;
                    asm_d   = '0;
                    bcnt_d  = '0;
                    addr_d  = '0;
                    wcnt_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (byte_take_s) begin
                    asm_d = {asm_q[NB_DATA-NBYTE-1:0], bus.byte_i};
`ifdef INST_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.byte_i;
`endif
                    if (bcnt_q == LAST_BYTE) begin
                        // Latch the completed word onto the memory port for WRITE.
                        bcnt_d  = '0;
                        wdata_d = {asm_q[NB_DATA-NBYTE-1:0], bus.byte_i};
                        waddr_d = addr_q;
                        state_d = ST_WRITE;
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                wcnt_d = wcnt_q + 1'b1;
                if ((wdata_q == HALT_WORD) || (addr_q == LAST_ADDR)) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_take_s) begin
                    err_d   = (bus.byte_i != xor_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            asm_q   <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.byte_ready_o     = byte_ready_s;
    assign bus.busy_o           = busy_s;
    assign bus.done_o           = (state_q == ST_DONE);
    assign bus.mem_en_write_o   = (state_q == ST_WRITE);
    assign bus.mem_data_o       = wdata_q;
    assign bus.mem_addr_write_o = waddr_q;
    assign bus.word_count_o     = wcnt_q;
    assign bus.mem_en_read_o    = bus.fetch_en_i & ~busy_s;
`ifdef INST_LOADER_CHECKSUM_EN
    assign bus.error_o          = err_q;
`else
    assign bus.error_o          = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader_ctrl.sv
// Directed bench for inst_loader_ctrl: back-to-back and gapped loads,
// full-depth load, reset mid-load, fetch gating and (optionally) checksum.
module tb_inst_loader_ctrl;
    logic clock_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    inst_loader_ctrl_if #(.NB_DATA(32), .NBYTE(8), .NB_ADDR(7)) bus ();

    inst_loader_ctrl dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clock_i = ~clock_i;

    // Write log captured from the memory port.
    logic [31:0] wr_data [0:255];
    logic [6:0]  wr_addr [0:255];
    int          wr_n = 0;

    always @(negedge clock_i) begin
        if (bus.mem_en_write_o === 1'b1 && wr_n < 256) begin
            wr_data[wr_n] = bus.mem_data_o;
            wr_addr[wr_n] = bus.mem_addr_write_o;
            wr_n = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; wait (bounded) for the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        for (int k = 0; k < 20 && !taken; k++) begin
            @(negedge clock_i);
            if (bus.byte_ready_o === 1'b1) taken = 1'b1;
            tick();
        end
        bus.byte_valid_i = 1'b0;
        if (!taken) begin
            errors++;
            $display("FAIL byte_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) send_byte(t[31-8*i -: 8], gap);
    endtask

    // Trailing checksum byte, only present when the checksum feature is built.
    task automatic send_csum(input logic [7:0] c);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(c, 0);
`else
        c = c;
`endif
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock_i);
            if (bus.done_o === 1'b1) seen = 1'b1;
            #1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done_o never rose");
        end
    endtask

    int base;

    initial begin
        reset_i          = 1'b1;
        bus.load_start_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        bus.fetch_en_i   = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("rst_busy",   {31'd0, bus.busy_o},         32'd0);
        chk("rst_done",   {31'd0, bus.done_o},         32'd0);
        chk("rst_ready",  {31'd0, bus.byte_ready_o},   32'd0);
        chk("rst_wen",    {31'd0, bus.mem_en_write_o}, 32'd0);
        chk("rst_wc",     {24'd0, bus.word_count_o},   32'd0);
        chk("rst_err",    {31'd0, bus.error_o},        32'd0);
        chk("rst_addr",   {25'd0, bus.mem_addr_write_o}, 32'd0);
        chk("rst_data",   bus.mem_data_o,              32'd0);
        chk("rst_rden",   {31'd0, bus.mem_en_read_o},  32'd1);
        tick();

        // Load 1: back-to-back bytes; byte offered during WRITE waits for RECV.
        pulse_start();
        @(negedge clock_i);
        chk("recv_busy",  {31'd0, bus.busy_o},        32'd1);
        chk("recv_ready", {31'd0, bus.byte_ready_o},  32'd1);
        chk("recv_rden",  {31'd0, bus.mem_en_read_o}, 32'd0);
        tick();
        send_word(32'h01020400, 0);
        send_byte(8'hAA, 0);
        pulse_start();                       // ignored while loading
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_word(32'hFFFFFFFF, 0);
        send_csum(8'h07);
        wait_done();
        chk("l1_nwr",   wr_n,              32'd3);
        chk("l1_a0",    {25'd0, wr_addr[0]}, 32'd0);
        chk("l1_d0",    wr_data[0],        32'h01020400);
        chk("l1_a1",    {25'd0, wr_addr[1]}, 32'd1);
        chk("l1_d1",    wr_data[1],        32'hAABBCCDD);
        chk("l1_a2",    {25'd0, wr_addr[2]}, 32'd2);
        chk("l1_d2",    wr_data[2],        32'hFFFFFFFF);
        chk("l1_done",  {31'd0, bus.done_o},        32'd1);
        chk("l1_wc",    {24'd0, bus.word_count_o},  32'd3);
        chk("l1_rden",  {31'd0, bus.mem_en_read_o}, 32'd1);
        chk("l1_haddr", {25'd0, bus.mem_addr_write_o}, 32'd2);
        chk("l1_err",   {31'd0, bus.error_o},       32'd0);

        // Load 2: same stream with 3-cycle gaps, restarted from DONE.
        tick();
        pulse_start();
        @(negedge clock_i);
        chk("l2_done_drop", {31'd0, bus.done_o},       32'd0);
        chk("l2_wc_clr",    {24'd0, bus.word_count_o}, 32'd0);
        tick();
        send_word(32'h01020400, 3);
        send_word(32'hAABBCCDD, 3);
        send_word(32'hFFFFFFFF, 3);
        send_csum(8'h07);
        wait_done();
        chk("l2_nwr", wr_n,                32'd6);
        chk("l2_a0",  {25'd0, wr_addr[3]}, 32'd0);
        chk("l2_d0",  wr_data[3],          32'h01020400);
        chk("l2_a1",  {25'd0, wr_addr[4]}, 32'd1);
        chk("l2_d1",  wr_data[4],          32'hAABBCCDD);
        chk("l2_a2",  {25'd0, wr_addr[5]}, 32'd2);
        chk("l2_d2",  wr_data[5],          32'hFFFFFFFF);
        chk("l2_wc",  {24'd0, bus.word_count_o}, 32'd3);

        // Load 3: 128 non-HALT words fill the memory and stop at address 127.
        tick();
        base = wr_n;
        pulse_start();
        for (int i = 0; i < 128; i++) send_word({4{i[7:0]}}, 0);
        send_csum(8'h00);
        wait_done();
        chk("l3_nwr",   wr_n - base,                   32'd128);
        chk("l3_alast", {25'd0, wr_addr[base+127]},    32'd127);
        chk("l3_dlast", wr_data[base+127],             32'h7F7F7F7F);
        chk("l3_a64",   {25'd0, wr_addr[base+64]},     32'd64);
        chk("l3_wc",    {24'd0, bus.word_count_o},     32'd128);
        chk("l3_done",  {31'd0, bus.done_o},           32'd1);
        chk("l3_haddr", {25'd0, bus.mem_addr_write_o}, 32'd127);

        // Load 4: reset after two bytes of the second word.
        tick();
        base = wr_n;
        pulse_start();
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("r4_busy", {31'd0, bus.busy_o},       32'd0);
        chk("r4_done", {31'd0, bus.done_o},       32'd0);
        chk("r4_rdy",  {31'd0, bus.byte_ready_o}, 32'd0);
        chk("r4_wc",   {24'd0, bus.word_count_o}, 32'd0);
        chk("r4_rden", {31'd0, bus.mem_en_read_o}, 32'd1);
        tick();
        bus.byte_i       = 8'h77;
        bus.byte_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        bus.byte_valid_i = 1'b0;
        chk("r4_nowr", wr_n - base, 32'd1);
        chk("r4_w0",   wr_data[base], 32'h11223344);
        base = wr_n;
        pulse_start();
        send_word(32'hAABBCCDD, 0);
        send_word(32'hFFFFFFFF, 0);
        send_csum(8'h00);
        wait_done();
        chk("r4_nwr2", wr_n - base,                32'd2);
        chk("r4_a0",   {25'd0, wr_addr[base]},     32'd0);
        chk("r4_d0",   wr_data[base],              32'hAABBCCDD);
        chk("r4_wc2",  {24'd0, bus.word_count_o},  32'd2);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum: HALT-only load with correct then wrong check byte.
        tick();
        pulse_start();
        send_word(32'hFFFFFFFF, 0);
        @(negedge clock_i);
        chk("cs_check_busy", {31'd0, bus.busy_o}, 32'd1);
        tick();
        send_byte(8'h00, 0);
        wait_done();
        chk("cs_ok_err",  {31'd0, bus.error_o}, 32'd0);
        tick();
        pulse_start();
        send_word(32'hFFFFFFFF, 0);
        send_byte(8'h01, 0);
        wait_done();
        chk("cs_bad_err",  {31'd0, bus.error_o}, 32'd1);
        chk("cs_bad_done", {31'd0, bus.done_o},  32'd1);
        tick();
        pulse_start();
        @(negedge clock_i);
        chk("cs_err_clr", {31'd0, bus.error_o}, 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
